// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_rx
//  Brief    : 8N1 UART receiver with an ASCII command-line decoder.
//             Lines of the form  C|c <hex><hex> [CR] LF  produce an 8-bit
//             command code, presented with a level-held valid/ack handshake.
//             Optional stop-bit framing check, enabled by defining the
//             macro FRAME_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int BAUD = 434            // clock cycles per bit, must be >= 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] command,
    output logic       cmd_valid,
    input  logic       cmd_ack,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(BAUD);

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(BAUD - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'((BAUD / 2) - 1);
`ifdef FRAME_CHECK_EN
    // Stop bit is sampled in its centre so it can be checked.
    localparam logic [c_cnt_w-1:0] c_stop_last = c_cnt_w'(BAUD - 1);
`else
    // Stop bit is not examined; release early so the next start edge is seen.
    localparam logic [c_cnt_w-1:0] c_stop_last = c_cnt_w'((BAUD / 2) - 1);
`endif

    localparam logic [1:0] c_err_frame   = 2'd0;
    localparam logic [1:0] c_err_syntax  = 2'd1;
    localparam logic [1:0] c_err_overrun = 2'd2;

    localparam logic [7:0] c_ch_lf    = 8'h0A;
    localparam logic [7:0] c_ch_cr    = 8'h0D;
    localparam logic [7:0] c_ch_upc   = 8'h43;   // 'C'
    localparam logic [7:0] c_ch_lowc  = 8'h63;   // 'c'

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE    = 3'd0,
        P_HI      = 3'd1,
        P_LO      = 3'd2,
        P_END     = 3'd3,
        P_DISCARD = 3'd4
    } p_state_t;

    // ------------------------------------------------------------------------
    // Hex digit decode: returns {is_hex, nibble}
    // ------------------------------------------------------------------------
    function automatic logic [4:0] hex_decode(input logic [7:0] ch);
        logic [7:0] diff;
        logic [4:0] res;
        res  = 5'd0;
        diff = 8'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            diff = ch - 8'h30;
            res  = {1'b1, diff[3:0]};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            diff = ch - 8'h37;
            res  = {1'b1, diff[3:0]};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            diff = ch - 8'h57;
            res  = {1'b1, diff[3:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic               rx_meta_q;
    logic               rx_sync_q;
    logic               rx_prev_q;
    logic               rx_fall;

    rx_state_t          r_state_q, r_state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         data_q, data_d;
    logic               byte_valid_q, byte_valid_d;
    logic               frame_err_q, frame_err_d;

    p_state_t           p_state_q, p_state_d;
    logic [3:0]         hi_q, hi_d;
    logic [3:0]         lo_q, lo_d;
    logic               cr_seen_q, cr_seen_d;
    logic [7:0]         command_q, command_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [4:0]         hex;
    logic               commit;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser plus one delay stage for falling-edge detection
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // ------------------------------------------------------------------------
    // Bit-level receiver state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            data_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Bit-level receiver next state: start validation, LSB-first data, stop
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d    = r_state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (r_state_q)
            R_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (rx_fall) begin
                    r_state_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d = '0;
                    // A line that has returned high was only a glitch.
                    r_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d     = '0;
                    data_d    = {rx_sync_q, data_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (cnt_q == c_stop_last) begin
                    cnt_d        = '0;
                    byte_valid_d = 1'b1;
`ifdef FRAME_CHECK_EN
                    frame_err_d  = ~rx_sync_q;
`else
                    frame_err_d  = 1'b0;
`endif
                    r_state_d    = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Parser and output handshake registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q   <= P_IDLE;
            hi_q        <= 4'd0;
            lo_q        <= 4'd0;
            cr_seen_q   <= 1'b0;
            command_q   <= 8'd0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            p_state_q   <= p_state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cr_seen_q   <= cr_seen_d;
            command_q   <= command_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign hex = hex_decode(data_q);

    // ------------------------------------------------------------------------
    // Line parser next state, error reporting and command commit/ack
    // ------------------------------------------------------------------------
    always_comb begin
        p_state_d   = p_state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cr_seen_d   = cr_seen_q;
        command_d   = command_q;
        cmd_valid_d = cmd_valid_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        commit      = 1'b0;

        if (byte_valid_q) begin
            if (frame_err_q) begin
                // A corrupt byte poisons the rest of the line.
                err_d      = 1'b1;
                err_code_d = c_err_frame;
                p_state_d  = P_DISCARD;
            end else begin
                case (p_state_q)
                    P_IDLE: begin
                        if (data_q == c_ch_upc || data_q == c_ch_lowc) begin
                            p_state_d = P_HI;
                        end else if (data_q != c_ch_lf && data_q != c_ch_cr) begin
                            err_d      = 1'b1;
                            err_code_d = c_err_syntax;
                            p_state_d  = P_DISCARD;
                        end
                    end
                    P_HI: begin
                        if (hex[4]) begin
                            hi_d      = hex[3:0];
                            p_state_d = P_LO;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = c_err_syntax;
                            // An early LF still terminates the line.
                            p_state_d  = (data_q == c_ch_lf) ? P_IDLE : P_DISCARD;
                        end
                    end
                    P_LO: begin
                        if (hex[4]) begin
                            lo_d      = hex[3:0];
                            cr_seen_d = 1'b0;
                            p_state_d = P_END;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = c_err_syntax;
                            p_state_d  = (data_q == c_ch_lf) ? P_IDLE : P_DISCARD;
                        end
                    end
                    P_END: begin
                        if (data_q == c_ch_lf) begin
                            commit    = 1'b1;
                            p_state_d = P_IDLE;
                        end else if (data_q == c_ch_cr && !cr_seen_q) begin
                            cr_seen_d = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = c_err_syntax;
                            p_state_d  = P_DISCARD;
                        end
                    end
                    P_DISCARD: begin
                        if (data_q == c_ch_lf) begin
                            p_state_d = P_IDLE;
                        end
                    end
                    default: begin
                        p_state_d = P_IDLE;
                    end
                endcase
            end
        end

        // An ack in the commit cycle frees the slot for the new code.
        if (commit) begin
            if (!cmd_valid_q || cmd_ack) begin
                command_d   = {hi_q, lo_q};
                cmd_valid_d = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = c_err_overrun;
            end
        end else if (cmd_ack) begin
            cmd_valid_d = 1'b0;
        end
    end

    assign command   = command_q;
    assign cmd_valid = cmd_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign busy      = (p_state_q != P_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_rx
//  Brief    : Directed self-checking bench for uart_cmd_rx (BAUD = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

    localparam int BAUD = 16;
    localparam int HALF = BAUD / 2;
    // Negedges after driving the LF start bit at which cmd_valid first reads 1:
    // 2 sync + 1 edge-detect + start/data/stop counting + byte_valid + commit.
`ifdef FRAME_CHECK_EN
    localparam int RISE_AT = 4 + HALF + 9 * BAUD;
`else
    localparam int RISE_AT = 4 + 2 * HALF + 8 * BAUD;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       cmd_ack;
    logic [7:0] command;
    logic       cmd_valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int         checks   = 0;
    int         errors   = 0;
    int         err_seen = 0;
    logic [1:0] last_code = 2'd3;
    int         rise_at;
    int         e_base;

    uart_cmd_rx #(.BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .command   (command),
        .cmd_valid (cmd_valid),
        .cmd_ack   (cmd_ack),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count error pulses and remember the code attached to each.
    always @(negedge clk) begin
        if (err === 1'b1) begin
            err_seen  <= err_seen + 1;
            last_code <= err_code;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive ncells bit cells of an 8N1 frame; note when cmd_valid rises.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncells);
        logic [9:0] bits;
        logic       prev_v;
        bits    = {stop_bit, b, 1'b0};
        rise_at = -1;
        prev_v  = cmd_valid;
        for (int n = 0; n < ncells * BAUD; n++) begin
            @(negedge clk);
            if (rise_at < 0 && prev_v === 1'b0 && cmd_valid === 1'b1) rise_at = n;
            prev_v = cmd_valid;
            rx     = bits[n / BAUD];
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_frame(s[i], 1'b1, 10);
        end
        idle(BAUD);
    endtask

    task automatic ack_and_check(input string tag);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check(tag, 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        cmd_ack = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_command",  32'(command),   32'h00);
        check("rst_valid",    32'(cmd_valid), 32'd0);
        check("rst_err",      32'(err),       32'd0);
        check("rst_err_code", 32'(err_code),  32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        idle(4);

        // Basic line, commit latency, hold and ack
        send_line("C0A\n");
        check("t1_latency", 32'(rise_at),  32'(RISE_AT));
        check("t1_command", 32'(command),  32'h0A);
        check("t1_valid",   32'(cmd_valid), 32'd1);
        check("t1_no_err",  32'(err_seen), 32'd0);
        idle(20);
        check("t1_hold",    32'(cmd_valid), 32'd1);
        ack_and_check("t1_ack");
        idle(4);
        check("t1_ack_idle", 32'(cmd_valid), 32'd0);

        // Lower-case lead, lower-case hex, CR before LF
        send_line("c3f\r\n");
        check("t2_command", 32'(command),   32'h3F);
        check("t2_valid",   32'(cmd_valid), 32'd1);
        check("t2_no_err",  32'(err_seen),  32'd0);
        ack_and_check("t2_ack");

        // Bad hex digit then a good line
        send_line("C1G\n");
        check("t3_err_cnt",  32'(err_seen),  32'd1);
        check("t3_err_code", 32'(last_code), 32'd1);
        check("t3_no_valid", 32'(cmd_valid), 32'd0);
        check("t3_not_busy", 32'(busy),      32'd0);
        send_line("C05\n");
        check("t3_command",  32'(command),   32'h05);
        check("t3_valid",    32'(cmd_valid), 32'd1);
        check("t3_err_once", 32'(err_seen),  32'd1);
        check("t3_code_hold", 32'(err_code), 32'd1);
        ack_and_check("t3_ack");

        // Overrun: second line without an ack in between
        send_line("C11\n");
        send_line("C22\n");
        check("t4_command",  32'(command),   32'h11);
        check("t4_valid",    32'(cmd_valid), 32'd1);
        check("t4_err_cnt",  32'(err_seen),  32'd2);
        check("t4_err_code", 32'(last_code), 32'd2);
        ack_and_check("t4_ack");

        // Short low glitch is rejected by start-bit validation
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(2 * BAUD);
        check("t5_glitch_busy", 32'(busy), 32'd0);
        send_line("C7E\n");
        check("t5_command", 32'(command),   32'h7E);
        check("t5_valid",   32'(cmd_valid), 32'd1);
        check("t5_no_err",  32'(err_seen),  32'd2);
        ack_and_check("t5_ack");

`ifdef FRAME_CHECK_EN
        // Framing error discards the rest of the line
        send_frame(8'h43, 1'b0, 10);
        idle(2 * BAUD);
        check("t6_err_cnt",  32'(err_seen),  32'd3);
        check("t6_err_code", 32'(last_code), 32'd0);
        check("t6_busy",     32'(busy),      32'd1);
        check("t6_no_valid", 32'(cmd_valid), 32'd0);
        send_line("01\nC02\n");
        check("t6_command",  32'(command),   32'h02);
        check("t6_valid",    32'(cmd_valid), 32'd1);
        check("t6_err_once", 32'(err_seen),  32'd3);
        ack_and_check("t6_ack");
`endif

        // Reset in the middle of a data bit
        e_base = err_seen;
        send_frame(8'h43, 1'b1, 4);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_rst_valid",    32'(cmd_valid), 32'd0);
        check("t7_rst_busy",     32'(busy),      32'd0);
        check("t7_rst_err_code", 32'(err_code),  32'd0);
        check("t7_rst_command",  32'(command),   32'h00);
        idle(2 * BAUD);
        check("t7_no_spurious",  32'(cmd_valid), 32'd0);
        send_line("C33\n");
        check("t7_command", 32'(command),   32'h33);
        check("t7_valid",   32'(cmd_valid), 32'd1);
        check("t7_no_err",  32'(err_seen),  32'(e_base));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Receive-side counterpart of the command transmitter: deserialises a 115200-baud 8N1 UART stream from the PC and decodes ASCII command lines into an 8-bit command code.
- Line format: 'C' or 'c', two hex digits, optional CR, then LF. "C0A\n" yields command 0x0A.
- Output uses a level-held valid/ack handshake so the existing command consumer (str/ready_command style) can be attached directly.

Parameters:
- BAUD, 434, clock cycles per bit (50 MHz / 115200); must be >= 8.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, synchronous, active-high
- rx  input  1  serial data from PC, idle high, asynchronous to clk
- command  output  8  decoded command code
- cmd_valid  output  1  high while command holds an unconsumed code
- cmd_ack  input  1  consumer accepts command; clears cmd_valid
- err  output  1  one-cycle error pulse
- err_code  output  2  cause of the last err: 0 framing, 1 syntax, 2 overrun
- busy  output  1  high while the parser is mid-line (any state other than P_IDLE)

Behaviour:
- Reset values: command=0, cmd_valid=0, err=0, err_code=0, busy=0, rx synchroniser=1, both FSMs idle. Reset asserted mid-byte or mid-line discards all partial data.
- rx input: 2-flop synchroniser, then edge detect.
- Bit FSM states:
  - R_IDLE: on a synchronised falling edge, go to R_START.
  - R_START: count BAUD/2 (integer division). If rx is still 0, go to R_DATA; else treat as a glitch and return to R_IDLE without reporting.
  - R_DATA: sample 8 bits, LSB first, one every BAUD cycles.
  - R_STOP: sample after BAUD cycles. Assert an internal byte_valid for one cycle in the cycle after the stop sample, then go to R_IDLE.
- Stop bit = 0 is a framing error: err pulse with err_code=0; the byte is dropped and the parser goes to P_DISCARD.
- Parser states, advanced only on byte_valid:
  - P_IDLE:
    - 'C'/'c' -> P_HI.
    - LF or CR -> ignored, stay in P_IDLE.
    - Any other byte -> syntax err, P_DISCARD.
  - P_HI:
    - Hex digit (0-9, A-F, a-f) -> store as the high nibble, P_LO.
    - Otherwise -> syntax err, P_DISCARD.
  - P_LO:
    - Hex digit -> store as the low nibble, P_END.
    - Otherwise -> syntax err, P_DISCARD.
  - P_END:
    - CR -> ignored once; a second CR is a syntax err.
    - LF -> commit, P_IDLE.
    - Any other byte -> syntax err, P_DISCARD.
  - P_DISCARD:
    - LF -> P_IDLE.
    - All other bytes dropped silently.
  - In P_HI, P_LO and P_END, an LF received instead of the expected byte is a syntax err; the parser goes directly to P_IDLE (the LF ends the line).
- Commit:
  - cmd_valid=0: command <= {hi,lo}, cmd_valid <= 1 in the cycle after the LF byte_valid. Latency from the LF stop-bit sample to cmd_valid is 2 clk.
  - cmd_valid=1: new code dropped, command unchanged, err pulse with err_code=2.
- cmd_valid stays high until a cycle with cmd_ack=1, then clears in the next cycle.
- If cmd_ack and a commit occur in the same cycle, the ack clears the old code and the new code is loaded; cmd_valid stays 1 and no overrun is reported.
- cmd_ack while cmd_valid=0 is ignored.
- err_code holds its value until the next err.
- If framing and syntax errors coincide on the same byte, framing wins.

Optional Feature:
- FRAME_CHECK_EN
  - Defined: stop-bit check active, as above.
  - Undefined: stop bit is not examined, every byte is delivered, err_code=0 never occurs; R_STOP still waits BAUD/2 so the next start edge is not missed.

Test Plan:
- BAUD=16; send "C0A\n" -> command=0x0A, cmd_valid=1 two clk after the LF stop sample; pulse cmd_ack -> cmd_valid=0 next cycle.
- Send "c3f\r\n" -> command=0x3F, cmd_valid=1, no err.
- Send "C1G\n" then "C05\n" -> one err with err_code=1, no valid for the first line; second line gives command=0x05.
- Send "C11\n" and "C22\n" with no ack -> command stays 0x11, err with err_code=2 after the second LF.
- 5-cycle low glitch on rx, then "C7E\n" -> no err, command=0x7E.
- With FRAME_CHECK_EN: byte 'C' with stop=0 -> err_code=0; "01\nC02\n" -> command=0x02.
- Assert rst mid data bit of 'C', release, send "C33\n" -> command=0x33, no spurious valid or err.
